// File: rtl/score_digit_seq_if.sv
// Bus between the score source / VGA timing block and the score digit
// sequencer.
//   master : drives score, score_vld, x, y; observes busy and the renderer outputs
//   slave  : the sequencer itself
// Signals:
//   score[15:0], score_vld : binary score and its one-cycle load pulse
//   x[9:0], y[9:0]         : current pixel coordinates
//   busy                   : a conversion is pending or running
//   posx, posy, char, en   : registered digit cell / glyph select for the text renderer
//   bcd[19:0]              : committed digits {d4,d3,d2,d1,d0}
interface score_digit_seq_if;
  logic [15:0] score;
  logic        score_vld;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        busy;
  logic [9:0]  posx;
  logic [9:0]  posy;
  logic [3:0]  char;
  logic        en;
  logic [19:0] bcd;

  modport master (
    output score, score_vld, x, y,
    input  busy, posx, posy, char, en, bcd
  );

  modport slave (
    input  score, score_vld, x, y,
    output busy, posx, posy, char, en, bcd
  );
endinterface

// File: rtl/score_digit_seq.sv
// Score digit sequencer: converts a 16-bit binary score to five BCD digits
// with a serial double-dabble (one step per clock), commits the result only
// while the beam is outside the score rows, and maps the current pixel to a
// digit cell for the text renderer with leading-zero blanking.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   io  : score_digit_seq_if.slave (score input, pixel position, renderer outputs)
module score_digit_seq #(
  parameter logic [9:0] BASE_X = 10'd400,
  parameter logic [9:0] BASE_Y = 10'd40,
  parameter int         CHAR_W = 16,
  parameter int         CHAR_H = 32
) (
  input logic              clk,
  input logic              rst,
  score_digit_seq_if.slave io
);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_CONV        = 2'd1;
  localparam logic [1:0] S_WAIT_COMMIT = 2'd2;

  localparam int          LOG2W = $clog2(CHAR_W);
  // 11-bit field ends so the upper bound compare cannot wrap
  localparam logic [10:0] X_END = 11'(int'(BASE_X) + 5 * CHAR_W);
  localparam logic [10:0] Y_END = 11'(int'(BASE_Y) + CHAR_H);
  localparam logic [9:0]  CELL_MASK = ~10'(CHAR_W - 1);

  logic [1:0]  state_q,    state_d;
  logic [35:0] shift_q,    shift_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic        pend_q,     pend_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [19:0] shadow_q,   shadow_d;
  logic [19:0] bcd_q,      bcd_d;
  logic [9:0]  posx_q,     posx_d;
  logic [9:0]  posy_q,     posy_d;
  logic [3:0]  char_q,     char_d;
  logic        en_q,       en_d;

  logic [35:0] adj;
  logic [35:0] stepped;
  logic        y_outside;
  logic        hit;
  logic [9:0]  x_off;
  logic [9:0]  k;
  logic [3:0]  dig;
  logic        vis;

  // One double-dabble step: correct nibbles >= 5, then shift left.
  always_comb begin
    adj = shift_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (shift_q[16 + 4*i +: 4] >= 4'd5) begin
        adj[16 + 4*i +: 4] = shift_q[16 + 4*i +: 4] + 4'd3;
      end
    end
    stepped = adj << 1;
  end

  assign y_outside = (io.y < BASE_Y) || ({1'b0, io.y} >= Y_END);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    shadow_d   = shadow_q;
    bcd_d      = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (io.score_vld || pend_q) begin
          // a fresh pulse is newer than anything held in pending
          shift_d = {20'd0, (io.score_vld ? io.score : pend_val_q)};
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        shift_d = stepped;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          shadow_d = stepped[35:16];
          state_d  = S_WAIT_COMMIT;
        end
      end
      S_WAIT_COMMIT: begin
        if (y_outside) begin
          bcd_d   = shadow_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (io.score_vld && (state_q != S_IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = io.score;
    end
  end

  // Pixel to digit cell mapping; k = 0 is the leftmost (most significant) digit.
  always_comb begin
    hit   = (io.x >= BASE_X) && ({1'b0, io.x} < X_END) &&
            (io.y >= BASE_Y) && ({1'b0, io.y} < Y_END);
    x_off = io.x - BASE_X;
    k     = x_off >> LOG2W;
    case (k)
      10'd0:   dig = bcd_q[19:16];
      10'd1:   dig = bcd_q[15:12];
      10'd2:   dig = bcd_q[11:8];
      10'd3:   dig = bcd_q[7:4];
      10'd4:   dig = bcd_q[3:0];
      default: dig = '0;
    endcase
    // visible if this digit or any more significant one is nonzero; units always shown
    vis = (k == 10'd4);
    for (int unsigned j = 0; j < 5; j++) begin
      if ((10'(j) <= k) && (bcd_q[4*(4-j) +: 4] != 4'd0)) begin
        vis = 1'b1;
      end
    end
    posx_d = BASE_X;
    posy_d = BASE_Y;
    char_d = '0;
    en_d   = 1'b0;
    if (hit) begin
      posx_d = BASE_X + (x_off & CELL_MASK);
      char_d = dig;
      en_d   = vis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      shadow_q   <= '0;
      bcd_q      <= '0;
      posx_q     <= BASE_X;
      posy_q     <= BASE_Y;
      char_q     <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      shadow_q   <= shadow_d;
      bcd_q      <= bcd_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
      char_q     <= char_d;
      en_q       <= en_d;
    end
  end

  assign io.busy = pend_q | (state_q != S_IDLE);
  assign io.bcd  = bcd_q;
  assign io.posx = posx_q;
  assign io.posy = posy_q;
  assign io.char = char_q;
  assign io.en   = en_q;

endmodule

// File: tb/tb_score_digit_seq.sv
module tb_score_digit_seq;
  localparam logic [9:0] BX = 10'd400;
  localparam logic [9:0] BY = 10'd40;
  localparam int         CW = 16;
  localparam int         CH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_digit_seq_if bus ();

  score_digit_seq #(
    .BASE_X(BX),
    .BASE_Y(BY),
    .CHAR_W(CW),
    .CHAR_H(CH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [19:0] exp_q[$];
  logic [19:0] last_bcd;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v);
    bus.score     = v;
    bus.score_vld = 1'b1;
    tick();
    bus.score_vld = 1'b0;
  endtask

  // Waits (bounded) for bcd to move away from last_bcd; returns the new value.
  task automatic wait_bcd_change(input int budget, output logic [19:0] val, output bit ok);
    int n;
    ok  = 1'b0;
    val = last_bcd;
    n   = 0;
    while (!ok && n < budget) begin
      tick();
      n++;
      if (bus.bcd !== last_bcd) begin
        last_bcd = bus.bcd;
        val      = bus.bcd;
        ok       = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    bus.score = '0; bus.score_vld = 1'b0; bus.x = '0; bus.y = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    last_bcd = '0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.bcd !== 20'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 00000", bus.bcd); end
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus.en); end
    checks++; if (bus.char !== 4'd0) begin errors++; $display("FAIL reset_char: got %0d expected 0", bus.char); end
    checks++; if (bus.posx !== BX) begin errors++; $display("FAIL reset_posx: got %0d expected %0d", bus.posx, BX); end
    checks++; if (bus.posy !== BY) begin errors++; $display("FAIL reset_posy: got %0d expected %0d", bus.posy, BY); end
  endtask

  task automatic test_latency;
    logic [19:0] e;
    bus.y = '0; bus.x = '0;
    exp_q.push_back(to_bcd(1234));
    pulse(16'd1234);
    for (int c = 1; c <= 17; c++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL latency_busy_c%0d: got %b expected 1", c, bus.busy); end
      if (c == 17) begin
        checks++; if (bus.bcd !== last_bcd) begin errors++; $display("FAIL latency_early_commit: got %h expected %h", bus.bcd, last_bcd); end
      end
      tick();
    end
    e = exp_q.pop_front();
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL latency_bcd: got %h expected %h", bus.bcd, e); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL latency_busy_after: got %b expected 0", bus.busy); end
    last_bcd = bus.bcd;
  endtask

  task automatic test_extremes;
    logic [19:0] got, e;
    bit ok;
    int v, p;
    bus.y = '0; bus.x = '0;
    exp_q.push_back(to_bcd(65535));
    pulse(16'd65535);
    wait_bcd_change(40, got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL max_bcd: got %h expected %h", got, e); end
    exp_q.push_back(to_bcd(0));
    pulse(16'd0);
    wait_bcd_change(40, got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL zero_bcd: got %h expected %h", got, e); end
    v = 0;
    bus.y = BY + 10'd5;
    for (int k = 0; k < 5; k++) begin
      p = pow10(4 - k);
      bus.x = BX + 10'(k * CW + 7);
      tick();
      checks++; if (bus.en !== ((k == 4) || (v >= p))) begin errors++; $display("FAIL zero_en_k%0d: got %b expected %b", k, bus.en, (k == 4)); end
      if (k == 4) begin
        checks++; if (bus.char !== 4'((v / p) % 10)) begin errors++; $display("FAIL zero_char: got %0d expected 0", bus.char); end
      end
    end
    bus.x = '0; bus.y = '0;
    tick();
  endtask

  task automatic test_field_sweep;
    logic [19:0] got, e;
    bit ok;
    int v, p;
    bit exp_en;
    v = 42;
    bus.y = '0; bus.x = '0;
    exp_q.push_back(to_bcd(v));
    pulse(16'(v));
    wait_bcd_change(40, got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL sweep_bcd: got %h expected %h", got, e); end
    bus.y = BY;
    for (int k = 0; k < 5; k++) begin
      for (int off = 0; off < CW; off += CW - 1) begin
        p = pow10(4 - k);
        exp_en = (k == 4) || (v >= p);
        bus.x = BX + 10'(k * CW + off);
        tick();
        checks++; if (bus.en !== exp_en) begin errors++; $display("FAIL sweep_en_k%0d_o%0d: got %b expected %b", k, off, bus.en, exp_en); end
        checks++; if (bus.char !== 4'((v / p) % 10)) begin errors++; $display("FAIL sweep_char_k%0d: got %0d expected %0d", k, bus.char, (v / p) % 10); end
        checks++; if (bus.posx !== BX + 10'(k * CW)) begin errors++; $display("FAIL sweep_posx_k%0d: got %0d expected %0d", k, bus.posx, BX + 10'(k * CW)); end
        checks++; if (bus.posy !== BY) begin errors++; $display("FAIL sweep_posy_k%0d: got %0d expected %0d", k, bus.posy, BY); end
      end
    end
    // just outside each edge of the field
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin bus.x = BX - 10'd1;          bus.y = BY + 10'd3; end
        1: begin bus.x = BX + 10'(5 * CW);    bus.y = BY + 10'd3; end
        2: begin bus.x = BX + 10'(4 * CW);    bus.y = BY - 10'd1; end
        default: begin bus.x = BX + 10'(4 * CW); bus.y = BY + 10'(CH); end
      endcase
      tick();
      checks++; if (bus.en !== 1'b0 || bus.char !== 4'd0 || bus.posx !== BX || bus.posy !== BY) begin
        errors++; $display("FAIL outside_%0d: got en=%b char=%0d posx=%0d posy=%0d expected en=0 char=0 posx=%0d posy=%0d",
                           t, bus.en, bus.char, bus.posx, bus.posy, BX, BY);
      end
    end
    bus.x = '0; bus.y = '0;
  endtask

  task automatic test_hold_commit;
    logic [19:0] e;
    bus.x = '0; bus.y = BY;
    exp_q.push_back(to_bcd(777));
    pulse(16'd777);
    for (int i = 0; i < 30; i++) tick();
    checks++; if (bus.bcd !== last_bcd) begin errors++; $display("FAIL hold_bcd_top: got %h expected %h", bus.bcd, last_bcd); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", bus.busy); end
    bus.y = BY + 10'(CH - 1);
    tick();
    checks++; if (bus.bcd !== last_bcd) begin errors++; $display("FAIL hold_bcd_bottom: got %h expected %h", bus.bcd, last_bcd); end
    bus.y = BY + 10'(CH);
    tick();
    e = exp_q.pop_front();
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL hold_commit: got %h expected %h", bus.bcd, e); end
    last_bcd = bus.bcd;
    bus.y = '0;
  endtask

  task automatic test_back_to_back;
    logic [19:0] got, e;
    bit ok;
    bus.y = '0; bus.x = '0;
    exp_q.push_back(to_bcd(100));
    pulse(16'd100);
    tick(); tick();
    exp_q.push_back(to_bcd(200));
    pulse(16'd200);
    tick();
    // one-deep pending: the newer value replaces the queued one
    exp_q[exp_q.size() - 1] = to_bcd(300);
    pulse(16'd300);
    wait_bcd_change(40, got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL b2b_first: got %h expected %h", got, e); end
    wait_bcd_change(40, got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL b2b_second: got %h expected %h", got, e); end
    wait_bcd_change(40, got, ok);
    checks++; if (ok) begin errors++; $display("FAIL b2b_extra_commit: got %h expected no change", got); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_commit_collision;
    logic [19:0] got, e;
    bit ok;
    bus.y = '0; bus.x = '0;
    exp_q.push_back(to_bcd(11));
    pulse(16'd11);
    for (int i = 0; i < 16; i++) tick();
    exp_q.push_back(to_bcd(22));
    pulse(16'd22);
    e = exp_q.pop_front();
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL collide_first: got %h expected %h", bus.bcd, e); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL collide_busy: got %b expected 1", bus.busy); end
    last_bcd = bus.bcd;
    wait_bcd_change(40, got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL collide_second: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_abort;
    logic [19:0] got, e;
    bit ok;
    bus.y = '0; bus.x = '0;
    pulse(16'd999);
    tick(); tick();
    pulse(16'd500);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_bcd = '0;
    checks++; if (bus.bcd !== 20'h0) begin errors++; $display("FAIL abort_bcd: got %h expected 00000", bus.bcd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.en !== 1'b0 || bus.char !== 4'd0 || bus.posx !== BX || bus.posy !== BY) begin
      errors++; $display("FAIL abort_display: got en=%b char=%0d posx=%0d posy=%0d expected en=0 char=0 posx=%0d posy=%0d",
                         bus.en, bus.char, bus.posx, bus.posy, BX, BY);
    end
    wait_bcd_change(60, got, ok);
    checks++; if (ok) begin errors++; $display("FAIL abort_late_commit: got %h expected no change", got); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_later: got %b expected 0", bus.busy); end
    exp_q.push_back(to_bcd(55));
    pulse(16'd55);
    wait_bcd_change(40, got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL post_reset_bcd: got %h expected %h", got, e); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_extremes();
    test_field_sweep();
    test_hold_commit();
    test_back_to_back();
    test_commit_collision();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
